// File: rtl/sdram_host_pkg.sv
// Shared types and helpers for the SDRAM host request sequencer.
package sdram_host_pkg;

    localparam int unsigned DROP_CNT_W = 8;
    localparam int unsigned DROP_SUM_W = DROP_CNT_W + 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4
    } state_t;

    // Adds 0..2 dropped requests to the counter, clamping at all-ones.
    function automatic logic [DROP_CNT_W-1:0] sat_add(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [1:0]            inc
    );
        logic [DROP_SUM_W-1:0] sum;
        sum = {1'b0, cnt} + DROP_SUM_W'(inc);
        sat_add = sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_host_sequencer_req_slot.sv
// One-deep pending request register with optional payload and drop indication.
module req_slot #(
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned PW = (DATA_WIDTH == 0) ? 1 : DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          clr,
    input  logic [PW-1:0] data_in,
    output logic          pend,
    output logic [PW-1:0] data_out,
    output logic          drop_c
);

    logic accept_c;

    // A slot freed this cycle by its consumer can take a new request at once.
    assign drop_c   = req && pend && !clr;
    assign accept_c = req && !drop_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (req) begin
            pend <= 1'b1;
        end else if (clr) begin
            pend <= 1'b0;
        end
    end

    generate
        if (DATA_WIDTH == 0) begin : g_no_payload
            logic payload_unused;
            assign payload_unused = ^data_in;
            assign data_out       = '0;
        end else begin : g_payload
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out <= '0;
                end else if (accept_c) begin
                    data_out <= data_in;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sdram_host_sequencer.sv
// Sequences host write/read pulses into enable/busy handshakes with the SDRAM controller.
module sdram_host_sequencer
    import sdram_host_pkg::*;
#(
    parameter int unsigned HADDR_WIDTH = 24,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_req,
    input  logic                   rd_req,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic [HADDR_WIDTH-1:0] haddr,
    output logic [DATA_WIDTH-1:0]  data_input,
    output logic                   wr_enable,
    output logic                   rd_enable,
    input  logic                   busy,
    input  logic [DATA_WIDTH-1:0]  data_output,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   timeout_err,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    localparam int unsigned TO_W = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t                 state;
    logic [HADDR_WIDTH-1:0] wr_ptr;
    logic                   have_wr;
    logic [TO_W-1:0]        to_cnt;

    logic                   wr_pend;
    logic                   rd_pend;
    logic [DATA_WIDTH-1:0]  wr_pend_data;
    logic                   rd_slot_unused;
    logic                   wr_drop_c;
    logic                   rd_drop_c;
    logic                   wr_take_c;
    logic                   rd_take_c;
    logic [1:0]             drop_inc_c;

    // Slots hold requests not yet launched; launching from IDLE consumes them.
    assign wr_take_c  = (state == IDLE) && wr_pend;
    assign rd_take_c  = (state == IDLE) && !wr_pend && rd_pend;
    assign drop_inc_c = {1'b0, wr_drop_c} + {1'b0, rd_drop_c};

    req_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_slot (
        .clk      (clk),
        .rst      (rst),
        .req      (wr_req),
        .clr      (wr_take_c),
        .data_in  (wr_data),
        .pend     (wr_pend),
        .data_out (wr_pend_data),
        .drop_c   (wr_drop_c)
    );

    req_slot #(
        .DATA_WIDTH (0)
    ) u_rd_slot (
        .clk      (clk),
        .rst      (rst),
        .req      (rd_req),
        .clr      (rd_take_c),
        .data_in  (1'b0),
        .pend     (rd_pend),
        .data_out (rd_slot_unused),
        .drop_c   (rd_drop_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            have_wr     <= 1'b0;
            to_cnt      <= '0;
            haddr       <= '0;
            data_input  <= '0;
            wr_enable   <= 1'b0;
            rd_enable   <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            rd_valid    <= 1'b0;
            timeout_err <= 1'b0;
            drop_cnt    <= sat_add(drop_cnt, drop_inc_c);

            case (state)
                IDLE: begin
                    if (wr_pend) begin
                        state      <= WR_REQ;
                        wr_enable  <= 1'b1;
                        haddr      <= wr_ptr;
                        data_input <= wr_pend_data;
                        to_cnt     <= '0;
                    end else if (rd_pend) begin
                        state     <= RD_REQ;
                        rd_enable <= 1'b1;
                        haddr     <= have_wr ? (wr_ptr - HADDR_WIDTH'(1)) : '0;
                        to_cnt    <= '0;
                    end
                end

                WR_REQ: begin
                    if (busy) begin
                        state     <= WR_WAIT;
                        wr_enable <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        wr_enable   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                RD_REQ: begin
                    if (busy) begin
                        state     <= RD_WAIT;
                        rd_enable <= 1'b0;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= IDLE;
                        rd_enable   <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                // Address advances only once the controller has finished the write.
                WR_WAIT: begin
                    if (!busy) begin
                        wr_ptr  <= wr_ptr + HADDR_WIDTH'(1);
                        have_wr <= 1'b1;
                        state   <= IDLE;
                    end
                end

                RD_WAIT: begin
                    if (!busy) begin
                        rd_data  <= data_output;
                        rd_valid <= 1'b1;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    wr_enable <= 1'b0;
                    rd_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_host_sequencer.sv
// Scoreboard bench: stimulus queues expected launches/reads, a monitor checks them.
module tb_sdram_host_sequencer;
    import sdram_host_pkg::*;

    localparam int unsigned HW       = 24;
    localparam int unsigned DW       = 16;
    localparam int unsigned TO       = 8;
    localparam int unsigned ACK_DLY  = 2;
    localparam int unsigned BUSY_LEN = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_req;
    logic          rd_req;
    logic [DW-1:0] wr_data;
    logic [HW-1:0] haddr;
    logic [DW-1:0] data_input;
    logic          wr_enable;
    logic          rd_enable;
    logic          busy;
    logic [DW-1:0] data_output;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          timeout_err;
    logic [7:0]    drop_cnt;

    always #5 clk = ~clk;

    sdram_host_sequencer #(
        .HADDR_WIDTH (HW),
        .DATA_WIDTH  (DW),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .wr_data     (wr_data),
        .haddr       (haddr),
        .data_input  (data_input),
        .wr_enable   (wr_enable),
        .rd_enable   (rd_enable),
        .busy        (busy),
        .data_output (data_output),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .timeout_err (timeout_err),
        .drop_cnt    (drop_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [HW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    wr_exp_t       exp_wr[$];
    logic [HW-1:0] exp_rd_addr[$];
    logic [DW-1:0] exp_rd_data[$];
    bit            exp_to[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output with nothing expected", name);
    endtask

    // Controller model: busy rises ACK_DLY cycles after an enable, holds BUSY_LEN cycles.
    logic          ack_en;
    logic          stall;
    logic [DW-1:0] mem [int];
    int            m_ph;
    int            m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            data_output <= '0;
            m_ph        <= 0;
            m_cnt       <= 0;
        end else begin
            data_output <= mem.exists(int'(haddr)) ? mem[int'(haddr)] : '0;
            case (m_ph)
                0: if ((wr_enable || rd_enable) && ack_en) begin
                    m_ph  <= 1;
                    m_cnt <= ACK_DLY;
                end
                1: if (m_cnt == 1) begin
                    busy  <= 1'b1;
                    m_ph  <= 2;
                    m_cnt <= BUSY_LEN;
                    if (wr_enable) mem[int'(haddr)] = data_input;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                2: if (!stall) begin
                    if (m_cnt == 1) begin
                        busy <= 1'b0;
                        m_ph <= 3;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: if (!wr_enable && !rd_enable) m_ph <= 0;
            endcase
        end
    end

    // Monitor: compares every launch, read return and timeout against the queues.
    logic prev_wr = 1'b0;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        wr_exp_t e;
        if (wr_enable && rd_enable) begin
            n_vec++;
            n_err++;
            $display("FAIL enables_exclusive: wr_enable and rd_enable both 1");
        end
        if (wr_enable && !prev_wr) begin
            if (exp_wr.size() == 0) unexpected("wr_launch");
            else begin
                e = exp_wr.pop_front();
                chk("wr_haddr", 32'(haddr), 32'(e.addr));
                chk("wr_data_input", 32'(data_input), 32'(e.data));
            end
        end
        if (rd_enable && !prev_rd) begin
            if (exp_rd_addr.size() == 0) unexpected("rd_launch");
            else chk("rd_haddr", 32'(haddr), 32'(exp_rd_addr.pop_front()));
        end
        if (rd_valid) begin
            if (exp_rd_data.size() == 0) unexpected("rd_valid");
            else chk("rd_data", 32'(rd_data), 32'(exp_rd_data.pop_front()));
        end
        if (timeout_err) begin
            if (exp_to.size() == 0) unexpected("timeout_err");
            else void'(exp_to.pop_front());
        end
        prev_wr = wr_enable;
        prev_rd = rd_enable;
    end

    task automatic exp_write(input logic [HW-1:0] a, input logic [DW-1:0] d);
        exp_wr.push_back({a, d});
    endtask

    task automatic exp_read(input logic [HW-1:0] a, input logic [DW-1:0] d);
        exp_rd_addr.push_back(a);
        exp_rd_data.push_back(d);
    endtask

    task automatic pulse(input logic w, input logic r, input logic [DW-1:0] d);
        wr_req  = w;
        rd_req  = r;
        wr_data = d;
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        ack_en = 1'b1;
        stall  = 1'b0;
        mem.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(busy), 32'd1);
    endtask

    initial begin
        int hi;
        rst     = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_data = '0;
        ack_en  = 1'b1;
        stall   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_haddr", 32'(haddr), 32'd0);
        chk("rst_wr_enable", 32'(wr_enable), 32'd0);
        chk("rst_rd_enable", 32'(rd_enable), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write, enable held until busy, then pointer advances.
        exp_write(24'h0, 16'hA55A);
        pulse(1'b1, 1'b0, 16'hA55A);
        chk("t1_enable_n1", 32'(wr_enable), 32'd0);
        @(negedge clk);
        chk("t1_enable_n2", 32'(wr_enable), 32'd1);
        wait_busy("t1_busy_seen");
        chk("t1_enable_held", 32'(wr_enable), 32'd1);
        @(negedge clk);
        chk("t1_enable_drop", 32'(wr_enable), 32'd0);
        repeat (15) @(negedge clk);
        chk("t1_wr_ptr", 32'(dut.wr_ptr), 32'd1);

        // Two writes then a read of the latest address.
        do_reset();
        exp_write(24'h0, 16'h1111);
        exp_write(24'h1, 16'h2222);
        exp_read(24'h1, 16'h2222);
        pulse(1'b1, 1'b0, 16'h1111);
        pulse(1'b1, 1'b0, 16'h2222);
        pulse(1'b0, 1'b1, 16'h0);
        repeat (40) @(negedge clk);
        chk("t2_rd_data", 32'(rd_data), 32'h2222);
        chk("t2_drop_cnt", 32'(drop_cnt), 32'd0);

        // Simultaneous write and read: read returns the just-written word.
        do_reset();
        exp_write(24'h0, 16'h3C3C);
        exp_read(24'h0, 16'h3C3C);
        pulse(1'b1, 1'b1, 16'h3C3C);
        repeat (30) @(negedge clk);
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("t3_wr_ptr", 32'(dut.wr_ptr), 32'd1);

        // Drops during an active write, then saturation.
        do_reset();
        exp_write(24'h0, 16'hAAAA);
        exp_write(24'h1, 16'hB001);
        pulse(1'b1, 1'b0, 16'hAAAA);
        repeat (3) @(negedge clk);
        wr_req = 1'b1;
        wr_data = 16'hB001; @(negedge clk);
        wr_data = 16'hB002; @(negedge clk);
        wr_data = 16'hB003; @(negedge clk);
        wr_req = 1'b0;
        repeat (30) @(negedge clk);
        chk("t4_drop_cnt_2", 32'(drop_cnt), 32'd2);
        stall = 1'b1;
        exp_write(24'h2, 16'hC000);
        exp_write(24'h3, 16'hD000);
        pulse(1'b1, 1'b0, 16'hC000);
        repeat (8) @(negedge clk);
        pulse(1'b1, 1'b0, 16'hD000);
        wr_req  = 1'b1;
        wr_data = 16'hEEEE;
        repeat (300) @(negedge clk);
        wr_req = 1'b0;
        chk("t4_drop_cnt_sat", 32'(drop_cnt), 32'd255);
        stall = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_wr_ptr", 32'(dut.wr_ptr), 32'd4);
        chk("t4_drop_cnt_hold", 32'(drop_cnt), 32'd255);

        // Controller never acknowledges: timeout after ACK_TIMEOUT cycles.
        do_reset();
        ack_en = 1'b0;
        exp_write(24'h0, 16'hE5E5);
        exp_to.push_back(1'b1);
        pulse(1'b1, 1'b0, 16'hE5E5);
        hi = 0;
        repeat (30) begin
            @(negedge clk);
            if (wr_enable) hi++;
        end
        chk("t5_enable_cycles", 32'(hi), 32'd8);
        chk("t5_wr_ptr", 32'(dut.wr_ptr), 32'd0);
        ack_en = 1'b1;
        exp_read(24'h0, 16'h0000);
        pulse(1'b0, 1'b1, 16'h0);
        repeat (20) @(negedge clk);

        // Pointer wrap, then reset in the middle of a read.
        do_reset();
        force dut.wr_ptr = 24'hFFFFFF;
        @(negedge clk);
        release dut.wr_ptr;
        exp_write(24'hFFFFFF, 16'hF00F);
        exp_write(24'h000000, 16'h0FF0);
        exp_write(24'h000001, 16'h1234);
        exp_read(24'h000001, 16'h1234);
        pulse(1'b1, 1'b0, 16'hF00F);
        repeat (14) @(negedge clk);
        pulse(1'b1, 1'b0, 16'h0FF0);
        repeat (14) @(negedge clk);
        pulse(1'b1, 1'b0, 16'h1234);
        repeat (14) @(negedge clk);
        pulse(1'b0, 1'b1, 16'h0);
        repeat (20) @(negedge clk);
        chk("t6_rd_data", 32'(rd_data), 32'h1234);
        stall = 1'b1;
        exp_rd_addr.push_back(24'h1);
        pulse(1'b0, 1'b1, 16'h0);
        wait_busy("t6_busy_seen");
        @(negedge clk);
        chk("t6_in_rd_wait", 32'(dut.state), 32'(RD_WAIT));
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_haddr", 32'(haddr), 32'd0);
        chk("t6_rst_data_input", 32'(data_input), 32'd0);
        chk("t6_rst_rd_data", 32'(rd_data), 32'd0);
        chk("t6_rst_enables", 32'({wr_enable, rd_enable}), 32'd0);
        chk("t6_rst_pulses", 32'({rd_valid, timeout_err}), 32'd0);
        chk("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        stall = 1'b0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_after", 32'(dut.state), 32'(IDLE));
        chk("t6_wr_ptr_after", 32'(dut.wr_ptr), 32'd0);

        chk("end_wr_queue", 32'(exp_wr.size()), 32'd0);
        chk("end_rd_addr_queue", 32'(exp_rd_addr.size()), 32'd0);
        chk("end_rd_data_queue", 32'(exp_rd_data.size()), 32'd0);
        chk("end_timeout_queue", 32'(exp_to.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
